// File: rtl/multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: controller state encoding,
// default operand width and the step-counter width helper.
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int N_DEFAULT = 8;

  // Width needed to hold a shift count from 0 up to and including n.
  function automatic int step_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_step_counter.sv
// Counts completed shift steps of one multiply; cleared on load, saturates at N.
module shift_step_counter
  import multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Clr,
  input  logic                   En,
  output logic [step_w(N)-1:0]   Count,
  output logic                   Last
);

  localparam int W = step_w(N);
  localparam logic [W-1:0] COUNT_MAX  = W'(N);
  localparam logic [W-1:0] COUNT_LAST = W'(N - 1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Count <= '0;
    end else if (Clr) begin
      Count <= '0;
    end else if (En && (Count != COUNT_MAX)) begin
      Count <= Count + W'(1);
    end
  end

  assign Last = (Count == COUNT_LAST);

endmodule

// File: rtl/shift_add_control.sv
// Moore sequencer for the N-bit shift-add multiplier: issues Load, Ad and Sh
// strobes from the multiplier LSB and finishes with a held Done/Ack handshake.
module shift_add_control
  import multiplier_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   St,
  input  logic                   M,
  input  logic                   Ack,
  output logic                   Load,
  output logic                   Ad,
  output logic                   Sh,
  output logic                   Busy,
  output logic                   Done,
  output logic [step_w(N)-1:0]   Step
);

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   cnt_clr;
  logic   cnt_en;

  shift_step_counter #(
    .N(N)
  ) u_step_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .Clr     (cnt_clr),
    .En      (cnt_en),
    .Count   (Step),
    .Last    (last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs depend on state only; M, St and Ack steer the next state.
  always_comb begin
    state_nxt = IDLE;
    Load      = 1'b0;
    Ad        = 1'b0;
    Sh        = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        state_nxt = St ? LOAD : IDLE;
      end
      LOAD: begin
        Load      = 1'b1;
        Busy      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = TEST;
      end
      TEST: begin
        Busy      = 1'b1;
        state_nxt = M ? ADD : SHIFT;
      end
      ADD: begin
        Ad        = 1'b1;
        Busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        Sh        = 1'b1;
        Busy      = 1'b1;
        cnt_en    = 1'b1;
        state_nxt = last ? DONE : TEST;
      end
      DONE: begin
        Done      = 1'b1;
        state_nxt = Ack ? IDLE : DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_add_control.sv
// Randomized self-checking bench for shift_add_control with a product-register
// datapath model and a schedule-based reference of the expected strobes.
module tb_shift_add_control;
  import multiplier_pkg::*;

  localparam int N  = 8;
  localparam int SW = $clog2(N + 1);

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          St = 1'b0;
  logic          Ack = 1'b0;
  logic          M;
  logic          Load, Ad, Sh, Busy, Done;
  logic [SW-1:0] Step;

  shift_add_control #(.N(N)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .St      (St),
    .M       (M),
    .Ack     (Ack),
    .Load    (Load),
    .Ad      (Ad),
    .Sh      (Sh),
    .Busy    (Busy),
    .Done    (Done),
    .Step    (Step)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Datapath model: product register driven by the DUT strobes, M is its LSB.
  logic [2*N:0]   pr = '0;
  logic [N-1:0]   mcand = '0;
  logic [N-1:0]   mplier = '0;
  longint         cyc = 0;
  longint         load_tot = 0, ad_tot = 0, sh_tot = 0;

  assign M = pr[0];

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (Load) load_tot <= load_tot + 1;
    if (Ad)   ad_tot   <= ad_tot + 1;
    if (Sh)   sh_tot   <= sh_tot + 1;
    if (Load)    pr <= {{(N+1){1'b0}}, mplier};
    else if (Ad) pr[2*N:N] <= {1'b0, pr[2*N-1:N]} + {1'b0, mcand};
    else if (Sh) pr <= pr >> 1;
  end

  // Reference: on an accepted start the whole cycle-by-cycle output schedule
  // is built from the multiplier bits, then Done is held until Ack.
  typedef struct packed {
    logic          load;
    logic          ad;
    logic          sh;
    logic          busy;
    logic          done;
    logic [SW-1:0] step;
  } exp_t;

  function automatic exp_t mk(bit l, bit a, bit s, bit b, bit d, int st);
    return {l, a, s, b, d, SW'(st)};
  endfunction

  exp_t cur = '0;
  exp_t sched[$];
  int   mode = 0;   // 0 idle, 1 running through schedule, 2 holding result

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mode = 0;
      cur  = '0;
      sched.delete();
    end else begin
      case (mode)
        0: if (St) begin
          cur = mk(1, 0, 0, 1, 0, int'(cur.step));
          for (int i = 0; i < N; i++) begin
            sched.push_back(mk(0, 0, 0, 1, 0, i));
            if (mplier[i]) sched.push_back(mk(0, 1, 0, 1, 0, i));
            sched.push_back(mk(0, 0, 1, 1, 0, i));
          end
          mode = 1;
        end
        1: if (sched.size() != 0) begin
          cur = sched.pop_front();
        end else begin
          cur  = mk(0, 0, 0, 0, 1, N);
          mode = 2;
        end
        default: if (Ack) begin
          cur  = mk(0, 0, 0, 0, 0, N);
          mode = 0;
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    check("outputs", longint'({Load, Ad, Sh, Busy, Done, Step}), longint'(cur));
  end

  task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp,
                        input int ack_delay, input bit noise, input bit st_with_ack,
                        input longint exp_lat, input longint exp_prod);
    longint e0, l0, a0, s0;
    bit got;
    @(negedge Clk);
    mcand = mc; mplier = mp; St = 1'b1;
    l0 = load_tot; a0 = ad_tot; s0 = sh_tot;
    @(negedge Clk);
    St = 1'b0;
    e0 = cyc;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      if (Done) begin got = 1; break; end
      if (noise) begin
        St  = 1'($urandom_range(0, 1));
        Ack = 1'($urandom_range(0, 1));
      end
      @(negedge Clk);
    end
    St = 1'b0; Ack = 1'b0;
    if (!got) begin
      check("done_timeout", 0, 1);
      return;
    end
    check("done_latency", cyc - e0, exp_lat);
    check("load_count", load_tot - l0, 1);
    check("ad_count", ad_tot - a0, $countones(mp));
    check("sh_count", sh_tot - s0, N);
    check("done_step", longint'(Step), N);
    check("product", longint'(pr[2*N-1:0]), exp_prod);
    repeat (ack_delay) @(negedge Clk);
    check("done_held", longint'(Done), 1);
    Ack = 1'b1; St = st_with_ack;
    @(negedge Clk);
    Ack = 1'b0; St = 1'b0;
    repeat (2) @(negedge Clk);
    check("no_reload", load_tot - l0, 1);
  endtask

  initial begin
    logic [N-1:0] rmc, rmp;
    bit got;
    // Reset held with St high
    Reset_n = 1'b0; St = 1'b1;
    repeat (3) @(negedge Clk);
    check("reset_outputs", longint'({Load, Ad, Sh, Busy, Done, Step}), 0);
    Reset_n = 1'b1; St = 1'b0;
    repeat (3) @(negedge Clk);
    check("idle_after_reset", longint'({Load, Busy, Done}), 0);

    run_op(8'h07, 8'h00, 1, 0, 0, 17, 0);
    run_op(8'hFF, 8'hFF, 0, 0, 0, 25, 16'hFE01);
    run_op(8'h03, 8'hA5, 2, 0, 0, 21, 16'h01EF);
    run_op(8'h5A, 8'h3C, 5, 1, 1, 1 + 2*N + 4, 16'h5A * 16'h3C);

    // Asynchronous reset landing in an ADD cycle
    @(negedge Clk);
    mcand = 8'h11; mplier = 8'h81; St = 1'b1;
    @(negedge Clk);
    St = 1'b0;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (Ad) begin got = 1; break; end
      @(negedge Clk);
    end
    check("saw_add", longint'(got), 1);
    #2 Reset_n = 1'b0;
    #1 check("async_reset", longint'({Load, Ad, Sh, Busy, Done, Step}), 0);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    run_op(8'h11, 8'h81, 0, 0, 0, 1 + 2*N + 2, 16'h11 * 16'h81);

    for (int r = 0; r < 25; r++) begin
      rmc = N'($urandom);
      rmp = N'($urandom);
      run_op(rmc, rmp, $urandom_range(0, 4), 1, 1'($urandom_range(0, 1)),
             1 + 2*N + $countones(rmp), longint'(rmc) * longint'(rmp));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
